// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and helpers for the unified memory-port arbiter.
// Fetch and data paths share these encodings so the owner tag routes responses.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_t;

  typedef enum logic {
    OWN_IF,
    OWN_DM
  } mem_owner_t;

  localparam logic [7:0]  FETCH_BE    = 8'hFF;
  localparam logic [63:0] FETCH_WDATA = 64'd0;

  // Pick the 32-bit instruction word out of a 64-bit beat using address bit 2.
  function automatic logic [31:0] fetch_lane(input logic [63:0] beat, input logic hi);
    return hi ? beat[63:32] : beat[31:0];
  endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-outstanding memory port between instruction fetch and the
// MEM-stage load/store path; data has priority, fetch gets a starvation guard.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req_i,
  input  logic [63:0] if_addr_i,
  input  logic        if_kill_i,
  output logic        if_gnt_o,
  output logic        if_rvalid_o,
  output logic [31:0] if_rdata_o,
  input  logic        dm_req_i,
  input  logic        dm_we_i,
  input  logic [63:0] dm_addr_i,
  input  logic [63:0] dm_wdata_i,
  input  logic [7:0]  dm_be_i,
  output logic        dm_gnt_o,
  output logic        dm_rvalid_o,
  output logic [63:0] dm_rdata_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [63:0] bus_addr_o,
  output logic [63:0] bus_wdata_o,
  output logic [7:0]  bus_be_o,
  input  logic        bus_gnt_i,
  input  logic        bus_rvalid_i,
  input  logic [63:0] bus_rdata_i
);

  localparam logic [3:0] STARVE_LIMIT = 4'(STARVE_MAX);

  arb_state_t  state_reg, state_next;
  mem_owner_t  owner_reg, owner_next;
  logic [3:0]  starve_cnt_reg, starve_cnt_next;
  logic        kill_reg, kill_next;
  logic        bus_we_reg, bus_we_next;
  logic [63:0] bus_addr_reg, bus_addr_next;
  logic [63:0] bus_wdata_reg, bus_wdata_next;
  logic [7:0]  bus_be_reg, bus_be_next;
  logic        if_rvalid_reg, if_rvalid_next;
  logic [31:0] if_rdata_reg, if_rdata_next;
  logic        dm_rvalid_reg, dm_rvalid_next;
  logic [63:0] dm_rdata_reg, dm_rdata_next;
  logic        sel_if;
  logic        if_drop;

  // Fetch wins only when data is idle or fetch has waited through STARVE_MAX data grants.
  assign sel_if  = if_req_i && (!dm_req_i || (starve_cnt_reg == STARVE_LIMIT));
  assign if_drop = kill_reg || if_kill_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_DM;
      starve_cnt_reg <= 4'd0;
      kill_reg       <= 1'b0;
      bus_we_reg     <= 1'b0;
      bus_addr_reg   <= 64'd0;
      bus_wdata_reg  <= 64'd0;
      bus_be_reg     <= 8'd0;
      if_rvalid_reg  <= 1'b0;
      if_rdata_reg   <= 32'd0;
      dm_rvalid_reg  <= 1'b0;
      dm_rdata_reg   <= 64'd0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      starve_cnt_reg <= starve_cnt_next;
      kill_reg       <= kill_next;
      bus_we_reg     <= bus_we_next;
      bus_addr_reg   <= bus_addr_next;
      bus_wdata_reg  <= bus_wdata_next;
      bus_be_reg     <= bus_be_next;
      if_rvalid_reg  <= if_rvalid_next;
      if_rdata_reg   <= if_rdata_next;
      dm_rvalid_reg  <= dm_rvalid_next;
      dm_rdata_reg   <= dm_rdata_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    starve_cnt_next = starve_cnt_reg;
    kill_next       = kill_reg;
    bus_we_next     = bus_we_reg;
    bus_addr_next   = bus_addr_reg;
    bus_wdata_next  = bus_wdata_reg;
    bus_be_next     = bus_be_reg;
    if_rvalid_next  = 1'b0;
    if_rdata_next   = if_rdata_reg;
    dm_rvalid_next  = 1'b0;
    dm_rdata_next   = dm_rdata_reg;
    bus_req_o       = 1'b0;
    if_gnt_o        = 1'b0;
    dm_gnt_o        = 1'b0;

    case (state_reg)
      ARB_IDLE: begin
        if (if_req_i || dm_req_i) begin
          state_next = ARB_REQ;
          if (sel_if) begin
            owner_next      = OWN_IF;
            bus_we_next     = 1'b0;
            bus_addr_next   = if_addr_i;
            bus_wdata_next  = FETCH_WDATA;
            bus_be_next     = FETCH_BE;
            starve_cnt_next = 4'd0;
          end else begin
            owner_next     = OWN_DM;
            bus_we_next    = dm_we_i;
            bus_addr_next  = dm_addr_i;
            bus_wdata_next = dm_wdata_i;
            bus_be_next    = dm_be_i;
            if (if_req_i && (starve_cnt_reg != STARVE_LIMIT)) begin
              starve_cnt_next = starve_cnt_reg + 4'd1;
            end
          end
        end
      end

      ARB_REQ: begin
        bus_req_o = 1'b1;
        if (bus_gnt_i) begin
          state_next = ARB_WAIT;
          if_gnt_o   = (owner_reg == OWN_IF);
          dm_gnt_o   = (owner_reg == OWN_DM);
        end
        if ((owner_reg == OWN_IF) && if_kill_i) begin
          kill_next = 1'b1;
        end
      end

      ARB_WAIT: begin
        if (bus_rvalid_i) begin
          state_next = ARB_IDLE;
          kill_next  = 1'b0;
          if (owner_reg == OWN_DM) begin
            dm_rvalid_next = 1'b1;
            dm_rdata_next  = bus_rdata_i;
          end else if (!if_drop) begin
            // A kill arriving with the response still drops it.
            if_rvalid_next = 1'b1;
            if_rdata_next  = fetch_lane(bus_rdata_i, bus_addr_reg[2]);
          end
        end else if ((owner_reg == OWN_IF) && if_kill_i) begin
          kill_next = 1'b1;
        end
      end

      default: begin
        state_next = ARB_IDLE;
      end
    endcase
  end

  assign bus_we_o    = bus_we_reg;
  assign bus_addr_o  = bus_addr_reg;
  assign bus_wdata_o = bus_wdata_reg;
  assign bus_be_o    = bus_be_reg;
  assign if_rvalid_o = if_rvalid_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign dm_rvalid_o = dm_rvalid_reg;
  assign dm_rdata_o  = dm_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single loads/stores, fetch lanes, kill,
// starvation grant order, grant backpressure and mid-transaction reset.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req_i;
  logic [63:0] if_addr_i;
  logic        if_kill_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        dm_req_i;
  logic        dm_we_i;
  logic [63:0] dm_addr_i;
  logic [63:0] dm_wdata_i;
  logic [7:0]  dm_be_i;
  logic        dm_gnt_o;
  logic        dm_rvalid_o;
  logic [63:0] dm_rdata_o;
  logic        bus_req_o;
  logic        bus_we_o;
  logic [63:0] bus_addr_o;
  logic [63:0] bus_wdata_o;
  logic [7:0]  bus_be_o;
  logic        bus_gnt_i;
  logic        bus_rvalid_i;
  logic [63:0] bus_rdata_i;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mem_port_arbiter #(.STARVE_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req_i    (if_req_i),
    .if_addr_i   (if_addr_i),
    .if_kill_i   (if_kill_i),
    .if_gnt_o    (if_gnt_o),
    .if_rvalid_o (if_rvalid_o),
    .if_rdata_o  (if_rdata_o),
    .dm_req_i    (dm_req_i),
    .dm_we_i     (dm_we_i),
    .dm_addr_i   (dm_addr_i),
    .dm_wdata_i  (dm_wdata_i),
    .dm_be_i     (dm_be_i),
    .dm_gnt_o    (dm_gnt_o),
    .dm_rvalid_o (dm_rvalid_o),
    .dm_rdata_o  (dm_rdata_o),
    .bus_req_o   (bus_req_o),
    .bus_we_o    (bus_we_o),
    .bus_addr_o  (bus_addr_o),
    .bus_wdata_o (bus_wdata_o),
    .bus_be_o    (bus_be_o),
    .bus_gnt_i   (bus_gnt_i),
    .bus_rvalid_i(bus_rvalid_i),
    .bus_rdata_i (bus_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "simulation time limit reached");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Move to 1 time unit after the next rising edge; inputs change here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One data transaction with the bus granting immediately and responding a cycle later.
  task automatic data_txn(input logic we, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] be, input logic [63:0] rdata);
    dm_req_i = 1'b1; dm_we_i = we; dm_addr_i = addr; dm_wdata_i = wdata; dm_be_i = be;
    bus_gnt_i = 1'b1;
    #1;
    chk("dm_c0_bus_req", bus_req_o, 1'b0);
    tick(); #1;
    chk("dm_c1_gnt", dm_gnt_o, 1'b1);
    chk("dm_c1_if_gnt", if_gnt_o, 1'b0);
    chk("dm_c1_bus_req", bus_req_o, 1'b1);
    chk("dm_c1_we", bus_we_o, we);
    chk("dm_c1_addr", bus_addr_o, addr);
    chk("dm_c1_wdata", bus_wdata_o, wdata);
    chk("dm_c1_be", bus_be_o, be);
    tick();
    dm_req_i = 1'b0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = rdata;
    #1;
    chk("dm_c2_bus_req", bus_req_o, 1'b0);
    chk("dm_c2_rvalid", dm_rvalid_o, 1'b0);
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("dm_c3_rvalid", dm_rvalid_o, 1'b1);
    chk("dm_c3_rdata", dm_rdata_o, rdata);
    tick(); #1;
    chk("dm_c4_rvalid_pulse", dm_rvalid_o, 1'b0);
    chk("dm_c4_rdata_hold", dm_rdata_o, rdata);
  endtask

  // One fetch; kill_at: 0 none, 2 kill in WAIT before the response, 3 kill with the response.
  task automatic fetch_txn(input logic [63:0] addr, input logic [63:0] rdata, input int kill_at,
                           input logic exp_valid, input logic [31:0] exp_word);
    if_req_i = 1'b1; if_addr_i = addr; bus_gnt_i = 1'b1;
    tick(); #1;
    chk("if_c1_gnt", if_gnt_o, 1'b1);
    chk("if_c1_dm_gnt", dm_gnt_o, 1'b0);
    chk("if_c1_we", bus_we_o, 1'b0);
    chk("if_c1_be", bus_be_o, 8'hFF);
    chk("if_c1_wdata", bus_wdata_o, 64'd0);
    chk("if_c1_addr", bus_addr_o, addr);
    tick();
    if_req_i = 1'b0; bus_gnt_i = 1'b0;
    if (kill_at == 2) begin
      if_kill_i = 1'b1;
      tick();
      if_kill_i = 1'b0;
    end
    bus_rvalid_i = 1'b1; bus_rdata_i = rdata; if_kill_i = (kill_at == 3);
    #1;
    chk("if_wait_rvalid", if_rvalid_o, 1'b0);
    tick();
    bus_rvalid_i = 1'b0; if_kill_i = 1'b0;
    #1;
    chk("if_rsp_rvalid", if_rvalid_o, exp_valid);
    if (exp_valid) chk("if_rsp_rdata", if_rdata_o, exp_word);
    tick(); #1;
    chk("if_post_rvalid", if_rvalid_o, 1'b0);
  endtask

  logic got_if [10];
  logic exp_if [10];
  int   n_gnt;

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0; if_kill_i = 1'b0;
    dm_req_i = 1'b0; dm_we_i = 1'b0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
    bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
    tick(); tick(); #1;
    chk("rst_bus_req", bus_req_o, 1'b0);
    chk("rst_bus_addr", bus_addr_o, 64'd0);
    chk("rst_bus_be", bus_be_o, 8'd0);
    chk("rst_gnts", {if_gnt_o, dm_gnt_o}, 2'b00);
    chk("rst_rvalids", {if_rvalid_o, dm_rvalid_o}, 2'b00);
    chk("rst_rdata", {if_rdata_o, dm_rdata_o[31:0]}, 64'd0);
    tick();
    rst = 1'b0;

    // Single load at 0x1000, then a store with partial byte enables.
    data_txn(1'b0, 64'h1000, 64'h0, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    data_txn(1'b1, 64'h3000, 64'hAB, 8'h0F, 64'h0);

    // Fetch lane select: upper word for addr[2]=1, lower word otherwise.
    fetch_txn(64'h2004, 64'h11111111_22222222, 0, 1'b1, 32'h11111111);
    fetch_txn(64'h2000, 64'h11111111_22222222, 0, 1'b1, 32'h22222222);

    // Kill in WAIT drops the response; kill together with the response also drops it.
    fetch_txn(64'h2000, 64'h55555555_66666666, 2, 1'b0, 32'h0);
    fetch_txn(64'h2008, 64'h77777777_88888888, 3, 1'b0, 32'h0);
    fetch_txn(64'h200C, 64'h99999999_AAAAAAAA, 0, 1'b1, 32'h99999999);

    // Both requesters held: four data grants, then fetch forced first.
    exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    if_req_i = 1'b1; if_addr_i = 64'h4000;
    dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 64'h5000; dm_be_i = 8'hFF;
    bus_gnt_i = 1'b1; bus_rvalid_i = 1'b1; bus_rdata_i = 64'h0123_4567_89AB_CDEF;
    n_gnt = 0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (if_gnt_o || dm_gnt_o) begin
        got_if[n_gnt] = if_gnt_o;
        n_gnt++;
      end
      if (n_gnt == 10) break;
      tick();
    end
    chk("starve_grant_count", 64'(n_gnt), 64'd10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("starve_order_%0d", i), got_if[i], exp_if[i]);
    end
    tick();
    if_req_i = 1'b0; dm_req_i = 1'b0;
    tick();
    bus_rvalid_i = 1'b0; bus_gnt_i = 1'b0;
    tick(); #1;
    chk("starve_drain_idle", bus_req_o, 1'b0);

    // Grant backpressure: request and fields stay put until the bus accepts.
    dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 64'h6000; dm_wdata_i = 64'h1234; dm_be_i = 8'hF0;
    for (int c = 0; c < 5; c++) begin
      tick(); #1;
      chk("bp_bus_req", bus_req_o, 1'b1);
      chk("bp_no_gnt", dm_gnt_o, 1'b0);
      chk("bp_addr", bus_addr_o, 64'h6000);
      chk("bp_fields", {bus_we_o, bus_be_o, bus_wdata_o[15:0]}, {1'b1, 8'hF0, 16'h1234});
    end
    tick();
    bus_gnt_i = 1'b1;
    #1;
    chk("bp_gnt", dm_gnt_o, 1'b1);
    tick();
    dm_req_i = 1'b0; bus_gnt_i = 1'b0; rst = 1'b1;
    #1;
    chk("bp_wait_bus_req", bus_req_o, 1'b0);
    tick();
    rst = 1'b0; bus_rvalid_i = 1'b1; bus_rdata_i = 64'hFEED_FACE_0000_0001;
    #1;
    chk("mrst_bus_req", bus_req_o, 1'b0);
    chk("mrst_bus_addr", bus_addr_o, 64'd0);
    chk("mrst_bus_wdata", bus_wdata_o, 64'd0);
    chk("mrst_bus_we_be", {bus_we_o, bus_be_o}, 9'd0);
    chk("mrst_dm_rdata", dm_rdata_o, 64'd0);
    chk("mrst_if_rdata", if_rdata_o, 32'd0);
    tick();
    bus_rvalid_i = 1'b0;
    #1;
    chk("mrst_stray_dm_rvalid", dm_rvalid_o, 1'b0);
    chk("mrst_stray_if_rvalid", if_rvalid_o, 1'b0);
    chk("mrst_stray_bus_req", bus_req_o, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
